// File: rtl/fuzz_pkg.sv
// Shared types and LFSR helper for the fuzz stimulus player.
package fuzz_pkg;

    typedef enum logic [2:0] {IDLE, ZERO, LOAD, APPLY, DONE} state_e;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // One step of the 32-bit Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Rotate-and-xor MISR that compacts the DUT response into a signature.
module fuzz_misr #(
    parameter int OUT_W = 319
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] sig
);

    logic [OUT_W-1:0] sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= {sig_q[OUT_W-2:0], sig_q[OUT_W-1]} ^ din;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fuzz_stim_player.sv
// Seeded pseudo-random stimulus player with MISR response compaction.
// Optional macro STROBE_OUT_EN adds a registered per-sample strobe (smp_valid/smp_data).
module fuzz_stim_player
    import fuzz_pkg::*;
#(
    parameter int IN_W    = 63,
    parameter int OUT_W   = 319,
    parameter int NUM_VEC = 21,
    parameter int HOLD    = 2,
    localparam int W      = (IN_W + 31) / 32,
    localparam int CW     = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    vec_idx,
    output logic [OUT_W-1:0] signature
`ifdef STROBE_OUT_EN
    ,
    output logic             smp_valid,
    output logic [OUT_W-1:0] smp_data
`endif
);

    localparam int SW    = W * LFSR_W;
    localparam int CNT_M = (HOLD > W) ? HOLD : W;
    localparam int CNTW  = $clog2(CNT_M + 1);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [IN_W-1:0]   din_q, din_d;
    logic [CW-1:0]     vidx_q, vidx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              misr_clr, sample;
    logic [LFSR_W-1:0] word;
    logic [SW-1:0]     shift_nx;

    // First word loaded ends up in the most significant slot.
    assign word     = lfsr_next(lfsr_q);
    assign shift_nx = SW'({shift_q, word});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        shift_d  = shift_q;
        din_d    = din_q;
        vidx_d   = vidx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        misr_clr = 1'b0;
        sample   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (start && !busy_q) begin
                    misr_clr = 1'b1;
                    lfsr_d   = (seed == '0) ? 32'h1 : seed;
                    din_d    = '0;
                    vidx_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = ZERO;
                end
            end
            ZERO: begin
                if (cnt_q == CNTW'(HOLD - 1)) begin
                    sample  = 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                shift_d = shift_nx;
                lfsr_d  = word;
                if (cnt_q == CNTW'(W - 1)) begin
                    din_d   = shift_nx[IN_W-1:0];
                    vidx_d  = vidx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPLY: begin
                if (cnt_q == CNTW'(HOLD - 1)) begin
                    sample  = 1'b1;
                    cnt_d   = '0;
                    state_d = (vidx_q == CW'(NUM_VEC)) ? DONE : LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= 32'h1;
            shift_q <= '0;
            din_q   <= '0;
            vidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            shift_q <= shift_d;
            din_q   <= din_d;
            vidx_q  <= vidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    fuzz_misr #(.OUT_W(OUT_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (sample),
        .din   (dut_out),
        .sig   (signature)
    );

`ifdef STROBE_OUT_EN
    logic             smp_valid_q;
    logic [OUT_W-1:0] smp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
        end else begin
            smp_valid_q <= sample;
            if (sample) smp_data_q <= dut_out;
        end
    end

    assign smp_valid = smp_valid_q;
    assign smp_data  = smp_data_q;
`endif

    assign dut_in  = din_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign vec_idx = vidx_q;

endmodule

// File: doc/fuzz_stim_player.md
Name: fuzz_stim_player

Overview:
- Synthesizable, parametrised successor to the fixed-vector fuzz testbench driver.
- Generates a seeded pseudo-random stimulus stream of any width and applies it to a DUT instance, starting with an all-zero vector.
- Holds each vector for a programmable number of clocks and compacts the DUT output into a MISR signature.
- Sits beside the `top` instance in simulation and in on-FPGA equivalence runs, so different synthesis netlists can be compared by signature instead of by strobed text dumps.

Parameters:
- IN_W, 63: total DUT input width (the concatenated input bus).
- OUT_W, 319: DUT output width (y).
- NUM_VEC, 21: random vectors per run; the leading zero vector is not counted.
- HOLD, 2: clocks each vector is held; must be >= 1.
- Derived, not overridable: W = ceil(IN_W/32); CW = $clog2(NUM_VEC+1).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request; honoured only when busy=0.
- seed  in  32  LFSR seed, sampled when start is accepted.
- dut_in  out  IN_W  stimulus bus to the DUT.
- dut_out  in  OUT_W  DUT response (y).
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- vec_idx  out  CW  index of the vector currently applied (0 = zero vector).
- signature  out  OUT_W  MISR state.

Behaviour:
- Reset (asynchronous, active-low): dut_in=0, busy=0, done=0, vec_idx=0, signature=0, lfsr=1, state=IDLE.
- LFSR: 32-bit Galois.
  - next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - A seed of 0 is replaced by 1.
- MISR update on a sample: sig <= {sig[OUT_W-2:0], sig[OUT_W-1]} ^ dut_out.
- States:
  - IDLE: on start, sig<=0, lfsr<=seed (or 1 if seed is 0), dut_in<=0, vec_idx<=0, busy<=1, done<=0, then go to ZERO.
  - ZERO: hold dut_in=0 for HOLD clocks. On the last hold clock, sample dut_out into the MISR, then go to LOAD.
  - LOAD: W clocks. Each clock, shift <= {shift, lfsr} and advance the LFSR. dut_in keeps the previous vector during LOAD. On exit, dut_in <= shift[IN_W-1:0] (the first word ends up most significant, then truncation to IN_W), vec_idx increments, go to APPLY.
  - APPLY: hold for HOLD clocks; sample on the last one. If vec_idx==NUM_VEC, go to DONE; else go to LOAD.
  - DONE: busy=0, done=1, signature and dut_in frozen. A start here restarts from IDLE actions.
- Run length: done rises HOLD + NUM_VEC*(W+HOLD) + 1 clocks after the start edge. Total samples = NUM_VEC+1.
- start while busy=1: ignored, no effect on state or counters.
- rst_n low mid-run: immediate abort to reset values. The next run needs a fresh start.
- dut_out is only observed on sample clocks; its value at other times has no effect.

Optional Feature:
- Macro: STROBE_OUT_EN.
- Defined: adds outputs smp_valid (1 bit) and smp_data (OUT_W bits). smp_valid pulses for one clock, registered, on the cycle after each MISR sample, with smp_data = the sampled dut_out. This replaces the testbench's per-edge $strobe dump.
- Undefined: neither port exists, and no storage for them is built.

Decomposition:
- Package fuzz_pkg holds:
  - state enum {IDLE, ZERO, LOAD, APPLY, DONE};
  - LFSR_TAPS = 32'h80200003;
  - LFSR_W = 32;
  - function lfsr_next.
- One sub-module, fuzz_misr (parameter OUT_W; ports clk, rst_n, clr, en, din, sig), instantiated once. The LFSR stays inline.

Test Plan (IN_W=40, OUT_W=8, NUM_VEC=3, HOLD=2, W=2; loopback dut_out = dut_in[7:0] unless stated):
- Reset then idle: rst_n low 3 clocks -> all outputs 0; start never asserted -> dut_in stays 0 and busy stays 0.
- start with seed=32'h1 -> LFSR words 80200003, C0300002; first random dut_in = 40'h03C0300002 with vec_idx=1; done rises exactly 15 clocks after start; busy falls on the same clock.
- seed=32'h0 -> vector sequence and final signature identical to the seed=1 run.
- Same seed run twice -> identical signature. Forcing dut_out bit 3 inverted on the vec_idx=2 sample only -> final signature differs by 8'h10 (bit 3 rotated one position left by the single subsequent sample).
- start pulsed again at clock 6 of a run -> ignored, timing unchanged. rst_n pulsed low at clock 8 -> busy=0 and signature=0 immediately; a new start completes normally.
- STROBE_OUT_EN defined -> exactly 4 smp_valid pulses per run, with smp_data = 8'h00 first and then the low bytes of the three vectors.
